// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, MUL/DIV latency bounds
// and the per-cycle stage-control bundle.
package hazard_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_RUN    = 2'd0;
  localparam logic [STATE_W-1:0] ST_MULDIV = 2'd1;
  localparam logic [STATE_W-1:0] ST_FREEZE = 2'd2;

  localparam int MULDIV_LAT_MIN = 2;
  localparam int MULDIV_LAT_MAX = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
    logic pc_sel_redirect;
  } stage_ctl_t;

  // Bit order follows the struct fields: pc_en first, pc_sel_redirect last.
  localparam stage_ctl_t CTL_RUN      = 9'b1_1_0_1_0_1_0_1_0;
  localparam stage_ctl_t CTL_FREEZE   = 9'b0_0_0_0_0_0_0_0_0;
  localparam stage_ctl_t CTL_BUSY     = 9'b0_0_0_0_0_1_1_1_0;
  localparam stage_ctl_t CTL_LOAD_USE = 9'b0_0_0_1_1_1_0_1_0;
  localparam stage_ctl_t CTL_REDIRECT = 9'b1_1_1_1_0_1_0_1_1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder/cache-facing bundle of the hazard controller: hazard inputs in, stage enables out.
// master = pipeline side, slave = controller.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  import hazard_ctrl_pkg::*;

  logic              icache_stall;
  logic              dcache_stall;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              id_redirect;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_muldiv;

  logic               pc_en;
  logic               if_id_en;
  logic               if_id_flush;
  logic               id_ex_en;
  logic               id_ex_flush;
  logic               ex_mem_en;
  logic               ex_mem_flush;
  logic               mem_wb_en;
  logic               pc_sel_redirect;
  logic [STATE_W-1:0] state_o;

  modport master (
    output icache_stall, dcache_stall, id_rs, id_rt, id_uses_rt, id_redirect,
           ex_memread, ex_rt, ex_muldiv,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           ex_mem_flush, mem_wb_en, pc_sel_redirect, state_o
  );

  modport slave (
    input  icache_stall, dcache_stall, id_rs, id_rt, id_uses_rt, id_redirect,
           ex_memread, ex_rt, ex_muldiv,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           ex_mem_flush, mem_wb_en, pc_sel_redirect, state_o
  );

endinterface

// File: rtl/hazard_ctrl_muldiv.sv
// EX-occupancy down-counter for MUL/DIV ops: load on entry, decrement while busy,
// hold otherwise (including frozen cycles).
module muldiv_timer #(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic cnt_zero
);

  localparam int CNT_W = $clog2(MULDIV_LAT);

  logic [CNT_W-1:0] cnt;

  // The entry cycle and the release cycle are both part of the occupancy, hence LAT-2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MULDIV_LAT - 2);
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: advance/hold/flush per stage each cycle.
// Optional HAZARD_CTRL_PERF_EN adds freeze, bubble and redirect-flush event counters.
//
// state  | meaning
// RUN    | normal issue; load-use and redirect hazards resolved here
// MULDIV | MUL/DIV occupying EX; front end held until the timer reaches zero
// FREEZE | cache stall; every stage held, ret_state remembers where to resume
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int REG_AW     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_freeze_cyc,
  output logic [31:0]  perf_bubble_cyc,
  output logic [31:0]  perf_flush_cnt
`endif
);

  if (MULDIV_LAT < MULDIV_LAT_MIN || MULDIV_LAT > MULDIV_LAT_MAX) begin : g_bad_lat
    $error("hazard_ctrl: MULDIV_LAT out of range");
  end

  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  ex_rt;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] ret_state;
  logic [STATE_W-1:0] eff_state;
  logic [STATE_W-1:0] next_state;
  logic               freeze;
  logic               busy;
  logic               load_use;
  logic               cnt_zero;
  logic               timer_load;
  logic               timer_dec;
  stage_ctl_t         ctl;

  assign id_rs = bus.id_rs;
  assign id_rt = bus.id_rt;
  assign ex_rt = bus.ex_rt;

  // Leaving FREEZE behaves exactly as the state that was interrupted.
  assign eff_state = (state == ST_FREEZE) ? ret_state : state;
  assign freeze    = bus.icache_stall | bus.dcache_stall;
  assign busy      = ((eff_state == ST_MULDIV) && !cnt_zero) ||
                     ((eff_state == ST_RUN) && bus.ex_muldiv);
  assign load_use  = bus.ex_memread && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (bus.id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    ctl        = CTL_RUN;
    next_state = ST_RUN;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        ctl        = CTL_FREEZE;
        next_state = ST_FREEZE;
      end else if (busy) begin
        ctl        = CTL_BUSY;
        next_state = ST_MULDIV;
        timer_load = (eff_state == ST_RUN);
        timer_dec  = (eff_state == ST_MULDIV);
      end else if (load_use) begin
        ctl = CTL_LOAD_USE;
      end else if (bus.id_redirect) begin
        ctl = CTL_REDIRECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
    end else begin
      state <= next_state;
      if (freeze && (state != ST_FREEZE)) begin
        ret_state <= state;
      end
    end
  end

  muldiv_timer #(.MULDIV_LAT(MULDIV_LAT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .dec      (timer_dec),
    .cnt_zero (cnt_zero)
  );

  assign bus.pc_en           = ctl.pc_en;
  assign bus.if_id_en        = ctl.if_id_en;
  assign bus.if_id_flush     = ctl.if_id_flush;
  assign bus.id_ex_en        = ctl.id_ex_en;
  assign bus.id_ex_flush     = ctl.id_ex_flush;
  assign bus.ex_mem_en       = ctl.ex_mem_en;
  assign bus.ex_mem_flush    = ctl.ex_mem_flush;
  assign bus.mem_wb_en       = ctl.mem_wb_en;
  assign bus.pc_sel_redirect = ctl.pc_sel_redirect;
  assign bus.state_o         = state;

`ifdef HAZARD_CTRL_PERF_EN
  logic evt_bubble;
  logic evt_flush;

  assign evt_bubble = !freeze && (busy || load_use);
  assign evt_flush  = !freeze && !busy && !load_use && bus.id_redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_freeze_cyc <= '0;
      perf_bubble_cyc <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (freeze)     perf_freeze_cyc <= perf_freeze_cyc + 32'd1;
      if (evt_bubble) perf_bubble_cyc <= perf_bubble_cyc + 32'd1;
      if (evt_flush)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios then randomized traffic,
// compared each cycle against an occupancy-count reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int LAT = 4;
  localparam int AW  = 5;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, pc_sel_redirect}
  localparam logic [8:0] E_RUN   = 9'b110101010;
  localparam logic [8:0] E_BUSY  = 9'b000001110;
  localparam logic [8:0] E_LU    = 9'b000111010;
  localparam logic [8:0] E_REDIR = 9'b111101011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW)) bus ();

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_freeze_cyc, perf_bubble_cyc, perf_flush_cnt;
`endif

  hazard_ctrl #(.MULDIV_LAT(LAT), .REG_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_freeze_cyc (perf_freeze_cyc),
    .perf_bubble_cyc (perf_bubble_cyc),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: md_rem = non-frozen EX cycles still owed to the current MUL/DIV op (0 = none).
  int         md_rem = 0;
  logic [1:0] st_exp = 2'd0;
  bit         known  = 1'b0;
  int unsigned pf_frz = 0, pf_bub = 0, pf_fl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit is, input bit ds, input int rs, input int rt,
                       input bit urt, input bit redir, input bit mr, input int xrt, input bit md);
    rst_n            = r;
    bus.icache_stall = is;
    bus.dcache_stall = ds;
    bus.id_rs        = AW'(rs);
    bus.id_rt        = AW'(rt);
    bus.id_uses_rt   = urt;
    bus.id_redirect  = redir;
    bus.ex_memread   = mr;
    bus.ex_rt        = AW'(xrt);
    bus.ex_muldiv    = md;
  endtask

  task automatic cycle();
    logic [8:0] e, got;
    int         nrem;
    logic [1:0] nst;
    bit         lu, stall, ev_f, ev_b, ev_r;
    #1;
    stall = bus.icache_stall | bus.dcache_stall;
    lu = bus.ex_memread && (bus.ex_rt != 0) &&
         ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    nrem = md_rem; nst = st_exp; ev_f = 0; ev_b = 0; ev_r = 0;
    if (!rst_n) begin
      e = E_RUN; nrem = 0; nst = 2'd0;
    end else if (stall) begin
      e = '0; nst = 2'd2; ev_f = 1;
    end else if (md_rem > 1 || (md_rem == 0 && bus.ex_muldiv)) begin
      e = E_BUSY; nrem = (md_rem == 0) ? LAT - 1 : md_rem - 1; nst = 2'd1; ev_b = 1;
    end else begin
      nrem = 0; nst = 2'd0;
      if (lu) begin
        e = E_LU; ev_b = 1;
      end else if (bus.id_redirect) begin
        e = E_REDIR; ev_r = 1;
      end else begin
        e = E_RUN;
      end
    end
    got = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
           bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_en, bus.pc_sel_redirect};
    check("ctl", 32'(got), 32'(e));
    if (known) begin
      check("state", 32'(bus.state_o), 32'(st_exp));
`ifdef HAZARD_CTRL_PERF_EN
      check("perf_freeze", perf_freeze_cyc, pf_frz);
      check("perf_bubble", perf_bubble_cyc, pf_bub);
      check("perf_flush", perf_flush_cnt, pf_fl);
`endif
    end
    @(posedge clk);
    md_rem = nrem;
    st_exp = nst;
    if (!rst_n) begin
      pf_frz = 0; pf_bub = 0; pf_fl = 0; known = 1'b1;
    end else begin
      pf_frz += 32'(ev_f); pf_bub += 32'(ev_b); pf_fl += 32'(ev_r);
    end
    #1;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  initial begin
    // reset
    repeat (2) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); end
    idle();

    // load-use on r8, then cleared
    drive(1, 0, 0, 8, 3, 0, 0, 1, 8, 0); cycle();
    idle();
    // load-use through rt, and rt ignored when not used
    drive(1, 0, 0, 2, 9, 1, 0, 1, 9, 0); cycle();
    drive(1, 0, 0, 2, 9, 0, 0, 1, 9, 0); cycle();
    // $0 never hazards
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); cycle();

    // MUL/DIV held for its full latency
    repeat (LAT) begin drive(1, 0, 0, 1, 2, 0, 0, 0, 0, 1); cycle(); end
    idle();

    // freeze inside MULDIV
    drive(1, 0, 0, 1, 2, 0, 0, 0, 0, 1); cycle();
    repeat (5) begin drive(1, 0, 1, 1, 2, 0, 0, 0, 0, 1); cycle(); end
    repeat (LAT - 1) begin drive(1, 0, 0, 1, 2, 0, 0, 0, 0, 1); cycle(); end
    idle();

    // redirect concurrent with load-use, then redirect applied
    drive(1, 0, 0, 4, 0, 0, 1, 1, 4, 0); cycle();
    drive(1, 0, 0, 4, 0, 0, 1, 0, 4, 0); cycle();
    // redirect concurrent with freeze
    drive(1, 1, 0, 4, 0, 0, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 4, 0, 0, 1, 0, 0, 0); cycle();
    idle();

    // reset mid-freeze
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 6,
            $urandom_range(0, 3),
            $urandom_range(0, 3),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 35,
            $urandom_range(0, 3),
            $urandom_range(0, 99) < 8);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
